// File: rtl/pps_sync_tick_gen.sv
// Tick generator for the common time base: free-running divider whose phase is
// disciplined to an external 1 PPS input through an UNLOCKED/ACQUIRE/LOCKED/HOLDOVER lock machine.
`timescale 1ns/1ps
module pps_sync_tick_gen #(
    parameter int unsigned DIV           = 100000,
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned PPS_TOL       = 100,
    parameter int unsigned LOCK_COUNT    = 3,
    parameter int unsigned HOLDOVER_CLKS = 300000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pps_in,
    output logic        sync_signal,
    output logic [1:0]  state,
    output logic        locked,
    output logic [31:0] last_interval,
    output logic [15:0] pps_err_cnt
);

    localparam int unsigned DW       = $clog2(DIV);
    localparam int unsigned GW       = $clog2(LOCK_COUNT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [31:0] NOM      = DIV * TICKS_PER_SEC;
    localparam logic [31:0] NOM_LO   = NOM - PPS_TOL;
    localparam logic [31:0] NOM_HI   = NOM + PPS_TOL;
    localparam logic [31:0] TMO_CNT  = NOM_HI + 32'd1;
    localparam logic [31:0] HOLD_CNT = HOLDOVER_CLKS;
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } state_t;

    state_t          st_q, st_d;
    logic            s1, s2, s2_d;
    logic            pps_rise;
    logic [DW-1:0]   div_cnt;
    logic [31:0]     interval_cnt;
    logic [GW-1:0]   good_cnt;
    logic            seen_rise;
    logic            in_window, timed_out;
    logic            accept, err_inc, good_clr, good_inc;

    assign pps_rise  = s2 & ~s2_d;
    assign in_window = (interval_cnt >= NOM_LO) && (interval_cnt <= NOM_HI);
    // >= rather than == so a late rise ignored exactly at the limit cannot strand LOCKED
    assign timed_out = (interval_cnt >= TMO_CNT);

    assign state  = st_q;
    assign locked = (st_q == ST_LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= ST_UNLOCKED;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        accept   = 1'b0;
        err_inc  = 1'b0;
        good_clr = 1'b0;
        good_inc = 1'b0;
        case (st_q)
            ST_UNLOCKED: begin
                if (pps_rise) begin
                    accept   = 1'b1;
                    good_clr = 1'b1;
                    st_d     = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (pps_rise) begin
                    accept = 1'b1;
                    if (in_window) begin
                        good_inc = 1'b1;
                        if (good_cnt == GOOD_LAST) st_d = ST_LOCKED;
                    end else begin
                        good_clr = 1'b1;
                        err_inc  = 1'b1;
                    end
                end else if (timed_out) begin
                    st_d = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (pps_rise) begin
                    // early rises are treated as glitches: counted, never followed
                    if (in_window) accept  = 1'b1;
                    else           err_inc = 1'b1;
                end else if (timed_out) begin
                    err_inc = 1'b1;
                    st_d    = ST_HOLDOVER;
                end
            end
            ST_HOLDOVER: begin
                if (pps_rise) begin
                    accept   = 1'b1;
                    good_clr = 1'b1;
                    st_d     = ST_ACQUIRE;
                end else if (interval_cnt >= HOLD_CNT) begin
                    st_d = ST_UNLOCKED;
                end
            end
            default: st_d = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            s2_d          <= 1'b0;
            div_cnt       <= '0;
            sync_signal   <= 1'b0;
            interval_cnt  <= '0;
            last_interval <= '0;
            good_cnt      <= '0;
            seen_rise     <= 1'b0;
            pps_err_cnt   <= '0;
        end else begin
            s1   <= pps_in;
            s2   <= s1;
            s2_d <= s2;

            // a realign landing on terminal count is the same single pulse
            if (accept || (div_cnt == DIV_LAST)) begin
                div_cnt     <= '0;
                sync_signal <= 1'b1;
            end else begin
                div_cnt     <= div_cnt + 1'b1;
                sync_signal <= 1'b0;
            end

            if (accept) begin
                interval_cnt <= 32'd1;
            end else if (interval_cnt != '1) begin
                interval_cnt <= interval_cnt + 32'd1;
            end

            if (pps_rise) begin
                last_interval <= seen_rise ? interval_cnt : 32'd0;
                seen_rise     <= 1'b1;
            end

            if (good_clr) begin
                good_cnt <= '0;
            end else if (good_inc) begin
                good_cnt <= good_cnt + 1'b1;
            end

            if (err_inc && (pps_err_cnt != 16'hFFFF)) begin
                pps_err_cnt <= pps_err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pps_sync_tick_gen.sv
// Bench for pps_sync_tick_gen with small parameters (NOM=100, tol 2, lock 3, holdover 300):
// table of PPS gaps with expected status, a tick-phase scoreboard, and hand sequences for loss and reset.
`timescale 1ns/1ps
module tb_pps_sync_tick_gen;

    logic        clk;
    logic        rst_n;
    logic        pps_in;
    logic        sync_signal;
    logic [1:0]  state;
    logic        locked;
    logic [31:0] last_interval;
    logic [15:0] pps_err_cnt;

    pps_sync_tick_gen #(
        .DIV(10), .TICKS_PER_SEC(10), .PPS_TOL(2), .LOCK_COUNT(3), .HOLDOVER_CLKS(300)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pps_in(pps_in), .sync_signal(sync_signal),
        .state(state), .locked(locked), .last_interval(last_interval), .pps_err_cnt(pps_err_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // scoreboard: realign ticks are queued by the driver; free-run phase tracked per cycle
    logic [31:0] exp_q[$];
    bit  chk_en = 0;
    int  tick_phase = 0;
    int  pend_phase = 0;
    bit  pend_valid = 0;
    logic exp_tick;

    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            if (pend_valid && cyc >= pend_phase) begin
                tick_phase = pend_phase;
                pend_valid = 0;
            end
            exp_tick = (cyc >= tick_phase) && (((cyc - tick_phase) % 10) == 0);
            check("tick_phase", 32'(sync_signal), 32'(exp_tick));
            if (exp_q.size() > 0 && cyc == exp_q[0]) begin
                check("realign_tick", 32'(sync_signal), 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    // stimulus table
    typedef struct {
        int          gap;
        bit          realign;
        logic [1:0]  st;
        logic [31:0] last;
        logic [15:0] err;
    } row_t;

    row_t rows[21];
    int   last_drive = 0;

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic run_row(input int i);
        wait_until(last_drive + rows[i].gap);
        pps_in = 1'b1;
        last_drive = cyc;
        if (rows[i].realign) begin
            exp_q.push_back(32'(cyc + 3));
            pend_phase = cyc + 3;
            pend_valid = 1;
        end
        repeat (3) @(negedge clk);
        pps_in = 1'b0;
        check($sformatf("row%0d_state", i), 32'(state), 32'(rows[i].st));
        check($sformatf("row%0d_locked", i), 32'(locked), 32'(rows[i].st == 2'd2));
        check($sformatf("row%0d_last", i), last_interval, rows[i].last);
        check($sformatf("row%0d_err", i), 32'(pps_err_cnt), 32'(rows[i].err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sync"}, 32'(sync_signal), 32'd0);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_last"}, last_interval, 32'd0);
        check({tag, "_err"}, 32'(pps_err_cnt), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick_phase = cyc + 10;
        pend_valid = 0;
        last_drive = cyc;
        chk_en = 1;
    endtask

    initial begin
        int d;
        rows[0]  = '{7,   1'b1, 2'd1, 32'd0,   16'd0};
        rows[1]  = '{100, 1'b1, 2'd1, 32'd100, 16'd0};
        rows[2]  = '{100, 1'b1, 2'd1, 32'd100, 16'd0};
        rows[3]  = '{100, 1'b1, 2'd2, 32'd100, 16'd0};
        rows[4]  = '{50,  1'b0, 2'd2, 32'd50,  16'd1};
        rows[5]  = '{50,  1'b1, 2'd2, 32'd100, 16'd1};
        rows[6]  = '{45,  1'b0, 2'd2, 32'd45,  16'd2};
        rows[7]  = '{55,  1'b1, 2'd2, 32'd100, 16'd2};
        rows[8]  = '{150, 1'b1, 2'd1, 32'd150, 16'd3};
        rows[9]  = '{98,  1'b1, 2'd1, 32'd98,  16'd3};
        rows[10] = '{102, 1'b1, 2'd1, 32'd102, 16'd3};
        rows[11] = '{97,  1'b1, 2'd1, 32'd97,  16'd4};
        rows[12] = '{100, 1'b1, 2'd1, 32'd100, 16'd4};
        rows[13] = '{102, 1'b1, 2'd1, 32'd102, 16'd4};
        rows[14] = '{98,  1'b1, 2'd2, 32'd98,  16'd4};
        rows[15] = '{320, 1'b1, 2'd1, 32'd320, 16'd5};
        rows[16] = '{100, 1'b1, 2'd1, 32'd100, 16'd5};
        rows[17] = '{100, 1'b1, 2'd1, 32'd100, 16'd5};
        rows[18] = '{100, 1'b1, 2'd2, 32'd100, 16'd5};
        rows[19] = '{15,  1'b1, 2'd1, 32'd0,   16'd0};
        rows[20] = '{100, 1'b1, 2'd1, 32'd100, 16'd0};

        rst_n  = 1'b0;
        pps_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        release_reset();

        // free-run after reset, no PPS
        wait_until(last_drive + 35);
        check_all_zero("freerun");
        last_drive = cyc;

        // acquire, lock, glitches in LOCKED, HOLDOVER recovery, tolerance edges in ACQUIRE
        for (int i = 0; i <= 14; i++) run_row(i);

        // PPS loss: HOLDOVER at interval 103, UNLOCKED at 300
        d = last_drive;
        wait_until(d + 105);
        check("loss_pre_timeout_state", 32'(state), 32'd2);
        wait_until(d + 106);
        check("loss_holdover_state", 32'(state), 32'd3);
        check("loss_holdover_err", 32'(pps_err_cnt), 32'd5);
        check("loss_holdover_locked", 32'(locked), 32'd0);
        wait_until(d + 302);
        check("loss_pre_unlock_state", 32'(state), 32'd3);
        wait_until(d + 303);
        check("loss_unlocked_state", 32'(state), 32'd0);
        check("loss_unlocked_last", last_interval, 32'd98);

        for (int i = 15; i <= 18; i++) run_row(i);

        // asynchronous reset between ticks while LOCKED
        wait_until(last_drive + 8);
        chk_en = 0;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) @(negedge clk);
        check_all_zero("held_reset");
        release_reset();

        for (int i = 19; i <= 20; i++) run_row(i);

        wait_until(cyc + 20);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not finish at cyc %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
